// File: rtl/base_pkg.sv
// Shared bus types: APB request/response structs, response codes and the
// APB initiator FSM state encoding.
package base_pkg;

  localparam int unsigned APB_ADDR_WIDTH = 32;
  localparam int unsigned APB_DATA_WIDTH = 32;

  typedef struct packed {
    logic [APB_ADDR_WIDTH-1:0]   paddr;
    logic                        psel;
    logic                        penable;
    logic                        pwrite;
    logic [APB_DATA_WIDTH-1:0]   pwdata;
    logic [APB_DATA_WIDTH/8-1:0] pstrb;
    logic [2:0]                  pprot;
  } apb_req_t;

  typedef struct packed {
    logic                      pready;
    logic [APB_DATA_WIDTH-1:0] prdata;
    logic                      pslverr;
  } apb_resp_t;

  typedef enum logic [1:0] {
    RESP_OKAY    = 2'b00,
    RESP_SLVERR  = 2'b10,
    RESP_TIMEOUT = 2'b11
  } apb_resp_code_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_init_state_e;

endpackage

// File: rtl/apb_initiator.sv
// Single-outstanding APB initiator: one valid/ready command in, one APB
// transfer out, response held until consumed, watchdog aborts hung transfers.
module apb_initiator
  import base_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [2:0]  PPROT          = 3'b000,
  parameter type         req_t          = apb_req_t,
  parameter type         resp_t         = apb_resp_t
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]              rsp_resp_o,
  output req_t                    req_o,
  input  resp_t                   resp_i,
  output logic [1:0]              state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid must stay asserted with stable payload until then.

  localparam int unsigned WD_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  apb_init_state_e             state_q, state_d;
  logic                        cmd_ready_q, rsp_valid_q;
  logic                        psel_q, penable_q, pwrite_q;
  logic [ADDR_WIDTH-1:0]       paddr_q;
  logic [DATA_WIDTH-1:0]       pwdata_q, rdata_q;
  logic [DATA_WIDTH/8-1:0]     pstrb_q;
  logic [1:0]                  resp_q;
  logic [WD_W-1:0]             wdog_q, wdog_inc;
  logic                        cmd_fire, wd_expire;

  assign cmd_fire  = cmd_valid_i && cmd_ready_q;
  assign wdog_inc  = (wdog_q == {WD_W{1'b1}}) ? wdog_q : wdog_q + 1'b1;
  assign wd_expire = (TIMEOUT_CYCLES != 0) && (wdog_inc == WD_LIMIT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (cmd_fire) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (resp_i.pready || wd_expire) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
      psel_q      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_q   <= (state_d == ST_ACCESS);
      unique case (state_q)
        ST_IDLE: if (cmd_fire) begin
          paddr_q  <= cmd_addr_i;
          pwdata_q <= cmd_wdata_i;
          pwrite_q <= cmd_write_i;
          pstrb_q  <= cmd_write_i ? cmd_wstrb_i : '0;
          wdog_q   <= '0;
        end
        ST_ACCESS: begin
          // pready wins over a simultaneous watchdog expiry.
          if (resp_i.pready) begin
            rdata_q <= (!pwrite_q && !resp_i.pslverr) ? resp_i.prdata : '0;
            resp_q  <= resp_i.pslverr ? RESP_SLVERR : RESP_OKAY;
          end else begin
            wdog_q <= wdog_inc;
            if (wd_expire) begin
              rdata_q <= '0;
              resp_q  <= RESP_TIMEOUT;
            end
          end
        end
        ST_RESP: if (rsp_ready_i) begin
          wdog_q  <= '0;
          rdata_q <= '0;
          resp_q  <= RESP_OKAY;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_o         = '0;
    req_o.paddr   = paddr_q;
    req_o.psel    = psel_q;
    req_o.penable = penable_q;
    req_o.pwrite  = pwrite_q;
    req_o.pwdata  = pwdata_q;
    req_o.pstrb   = pstrb_q;
    req_o.pprot   = PPROT;
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_resp_o  = resp_q;
  assign state_o     = state_q;

endmodule
